div_unit: RTL and testbench
===========================

# div_unit

Iterative RV32M divide/remainder unit in the execute stage, alongside the single-cycle ALU. It accepts two 32-bit operands and an op code on a start pulse. It computes quotient or remainder with a radix-2 restoring algorithm, one bit per cycle, and returns a registered result with a one-cycle done pulse. The hazard logic uses busy to stall ID/EX while a division is in flight.

## Interface
- No parameters; width fixed at 32.
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when state is IDLE or DONE
- op  in  2  div_op_t: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- a  in  32  dividend, sampled with start
- b  in  32  divisor, sampled with start
- flush  in  1  pipeline flush; aborts any operation
- busy  out  1  high while state is CALC
- done  out  1  high for exactly one cycle (state DONE)
- res  out  32  registered result; held until next accepted start

## Operation
- FSM has three states: IDLE, CALC and DONE. Reset state is IDLE.
- Reset values: busy=0, done=0, res=0, counter=0, internal registers 0.
- IDLE/DONE with start=1 and flush=0 latches a, b and op.
  - Divide by zero (b=0) takes the fast path to DONE.
    - DIV and DIVU give res=32'hFFFF_FFFF.
    - REM and REMU give res=a.
  - Signed overflow (DIV/REM, a=32'h8000_0000, b=32'hFFFF_FFFF) takes the fast path to DONE.
    - DIV gives res=32'h8000_0000.
    - REM gives res=0.
  - All other cases go to CALC with counter=0.
    - Signed ops load |a| and |b|; unsigned ops load the operands unchanged.
    - Sign of the quotient (sa^sb) and sign of the remainder (sa) are recorded.
- CALC performs one restoring step per cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract divisor from rem, using a 33-bit subtract.
  - If the result is non-negative, keep it and set quo[0]=1.
- On the step where counter=31, the final step is computed.
  - Sign correction is applied: two's-complement negate when the recorded sign is set.
  - DIV/DIVU selects the quotient; REM/REMU selects the remainder.
  - The selected value is written to res, and the state moves to DONE.
- In DONE, done=1.
  - Next edge with start=1: accept a new op (back-to-back allowed).
  - Next edge with start=0: go to IDLE.
- start in CALC is ignored and is not queued.
- flush=1 in any state moves to IDLE on the next edge.
  - done is not asserted for the aborted op.
  - res keeps its previous value.
  - flush takes priority over start.
- Arithmetic is all modulo 2^32. The remainder path uses a 33-bit subtract so the borrow is visible.

## Timing
- E0 is the edge at which start is accepted.
- Normal path: CALC runs over edges E1..E32; DONE is visible after E32.
  - Latency from E0 to done is 33 cycles.
  - busy is high for 32 cycles.
- Fast path: DONE is visible after E0, a latency of 1 cycle. busy never rises.
- Back-to-back: start during the DONE cycle gives busy=1 in the next cycle, with no IDLE gap.
- res and done update on the same edge. Consumers sample res while done=1.
- Asynchronous reset mid-CALC gives IDLE with all outputs 0 immediately, without waiting for clk.
- All outputs are registered.

## Structure
- mriscv_pkg holds:
  - div_op_t enum (DIV, DIVU, REM, REMU)
  - div_state_t enum (IDLE, CALC, DONE)
  - DIV_STEPS=32 constant
- One natural sub-module, div_step: combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: rem_next, quo_next.
- div_unit holds the FSM, 5-bit counter, operand/sign registers and output register.

## Test plan
- DIVU a=100, b=7 -> done exactly 33 cycles after start, res=14; REMU same operands -> res=2.
- DIV a=-7 (FFFF_FFF9), b=2 -> res=FFFF_FFFD (-3); REM same operands -> res=FFFF_FFFF (-1); busy high exactly 32 cycles.
- DIV a=5, b=0 -> done 1 cycle after start, res=FFFF_FFFF; REMU a=5, b=0 -> res=5; busy never high.
- DIV a=8000_0000, b=FFFF_FFFF -> res=8000_0000, 1-cycle latency; REM same operands -> res=0.
- DIVU 100/7, then start DIVU 9/3 during its DONE cycle -> second done 33 cycles later, res=3; start pulsed mid-CALC is ignored and res stays 14 until the second done.
- Start DIVU 100/7, flush at cycle 10 -> IDLE next cycle, no done, res unchanged. Separately, rst_n low at cycle 20 of an op -> busy=0, done=0, res=0 asynchronously.

Source files
------------

// File: rtl/mriscv_pkg.sv
// Shared types for the execute-stage divide unit: op codes, FSM states
// and the iteration count of the radix-2 restoring divider.
`timescale 1ns/1ps
package mriscv_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_t;

    localparam int DIV_STEPS = 32;

    function automatic logic is_rem_op(input div_op_t o);
        return (o == REM) || (o == REMU);
    endfunction

    function automatic logic is_signed_op(input div_op_t o);
        return (o == DIV) || (o == REM);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on the {rem, quo} pair.
`timescale 1ns/1ps
module div_step (
    input  logic [31:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic [31:0] quo_next
);

    logic [31:0] shifted_low;
    logic [32:0] diff;
    logic        take;

    assign shifted_low = {rem[30:0], quo[31]};
    assign diff        = {1'b0, shifted_low} - {1'b0, divisor};
    // A set rem[31] means the shifted partial remainder is >= 2^32, which
    // always exceeds the divisor; the low 32 bits of diff are correct either way.
    assign take        = rem[31] | ~diff[32];
    assign rem_next    = take ? diff[31:0] : shifted_low;
    assign quo_next    = {quo[30:0], take};

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: one restoring step per cycle,
// fast path for divide-by-zero and signed overflow, registered result.
`timescale 1ns/1ps
module div_unit
    import mriscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] res
);

    div_state_t  state_reg;
    div_op_t     op_reg;
    logic [4:0]  cnt_reg;
    logic [31:0] rem_reg;
    logic [31:0] quo_reg;
    logic [31:0] divisor_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [31:0] res_reg;

    logic [31:0] rem_next;
    logic [31:0] quo_next;

    div_step u_step (
        .rem      (rem_reg),
        .quo      (quo_reg),
        .divisor  (divisor_reg),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    div_op_t     op_in;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        div_zero;
    logic        overflow;
    logic [31:0] fast_res;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [31:0] final_res;

    assign op_in    = div_op_t'(op);
    assign a_neg    = is_signed_op(op_in) & a[31];
    assign b_neg    = is_signed_op(op_in) & b[31];
    // |8000_0000| stays 8000_0000, which is the correct unsigned magnitude.
    assign abs_a    = a_neg ? -a : a;
    assign abs_b    = b_neg ? -b : b;
    assign div_zero = (b == 32'h0);
    assign overflow = is_signed_op(op_in) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign fast_res = is_rem_op(op_in) ? (div_zero ? a : 32'h0)
                                       : (div_zero ? 32'hFFFF_FFFF : 32'h8000_0000);

    assign q_fix     = neg_q_reg ? -quo_next : quo_next;
    assign r_fix     = neg_r_reg ? -rem_next : rem_next;
    assign final_res = is_rem_op(op_reg) ? r_fix : q_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            op_reg      <= DIV;
            cnt_reg     <= 5'd0;
            rem_reg     <= 32'h0;
            quo_reg     <= 32'h0;
            divisor_reg <= 32'h0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            res_reg     <= 32'h0;
        end else if (flush) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        op_reg      <= op_in;
                        divisor_reg <= abs_b;
                        if (div_zero || overflow) begin
                            res_reg   <= fast_res;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            rem_reg   <= 32'h0;
                            quo_reg   <= abs_a;
                            cnt_reg   <= 5'd0;
                            neg_q_reg <= a_neg ^ b_neg;
                            neg_r_reg <= a_neg;
                            busy_reg  <= 1'b1;
                            state_reg <= CALC;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                CALC: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    cnt_reg <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'(DIV_STEPS - 1)) begin
                        res_reg   <= final_res;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign res  = res_reg;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_div_unit;
    import mriscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        busy;
    logic        done;
    logic [31:0] res;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .res   (res)
    );

    // RISC-V M-extension semantics in plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int sx;
        int sy;
        logic ovf;
        sx  = x;
        sy  = y;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            2'b00:   return (y == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sx / sy));
            2'b01:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
            2'b10:   return (y == 0) ? x : (ovf ? 32'h0 : 32'(sx % sy));
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        if (y == 0) return 1;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op and measure it; returns latency, busy-cycle count, result
    // and the value of done one cycle after it was seen.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int busy_cyc, output logic [31:0] r,
                         output logic done_after);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_cyc = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        r = res;
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || res !== 32'h0) begin
            n_err++;
            $display("FAIL reset: busy=%b done=%b res=%h, required 0/0/0", busy, done, res);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_divide();
        logic [1:0]  ops [4] = '{2'b01, 2'b11, 2'b00, 2'b10};
        logic [31:0] xs  [4] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] ys  [4] = '{32'd7, 32'd7, 32'd2, 32'd2};
        int lat, bc;
        logic [31:0] r, e;
        logic da;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], xs[i], ys[i], lat, bc, r, da);
            e = ref_result(ops[i], xs[i], ys[i]);
            $display("divide op=%0d a=%h b=%h res=%h exp=%h lat=%0d busy=%0d", ops[i], xs[i], ys[i], r, e, lat, bc);
            n_vec++;
            if (r !== e) begin n_err++; $display("FAIL divide_res[%0d]: got %h, required %h", i, r, e); end
            n_vec++;
            if (lat !== 33) begin n_err++; $display("FAIL divide_lat[%0d]: got %0d, required 33", i, lat); end
            n_vec++;
            if (bc !== 32) begin n_err++; $display("FAIL divide_busy[%0d]: got %0d, required 32", i, bc); end
            n_vec++;
            if (da !== 1'b0) begin n_err++; $display("FAIL divide_done_width[%0d]: done=%b after one cycle, required 0", i, da); end
        end
    endtask

    task automatic test_fast_path();
        logic [1:0]  ops [5] = '{2'b00, 2'b11, 2'b00, 2'b10, 2'b01};
        logic [31:0] xs  [5] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] ys  [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        int lat, bc, el;
        logic [31:0] r, e;
        logic da;
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], xs[i], ys[i], lat, bc, r, da);
            e  = ref_result(ops[i], xs[i], ys[i]);
            el = ref_latency(ops[i], xs[i], ys[i]);
            $display("fast op=%0d a=%h b=%h res=%h exp=%h lat=%0d exp_lat=%0d", ops[i], xs[i], ys[i], r, e, lat, el);
            n_vec++;
            if (r !== e) begin n_err++; $display("FAIL fast_res[%0d]: got %h, required %h", i, r, e); end
            n_vec++;
            if (lat !== el) begin n_err++; $display("FAIL fast_lat[%0d]: got %0d, required %0d", i, lat, el); end
            n_vec++;
            if (bc !== ((el == 1) ? 0 : 32)) begin n_err++; $display("FAIL fast_busy[%0d]: got %0d busy cycles", i, bc); end
            n_vec++;
            if (da !== 1'b0) begin n_err++; $display("FAIL fast_done_width[%0d]: done=%b, required 0", i, da); end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int hold_bad;
        @(negedge clk);
        op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin @(negedge clk); cyc++; end
        n_vec++;
        if (res !== 32'd14 || done !== 1'b1) begin
            n_err++; $display("FAIL b2b_first: res=%h done=%b, required 0000000e/1", res, done);
        end
        op = 2'b01; a = 32'd9; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++; $display("FAIL b2b_no_gap: busy=%b done=%b, required 1/0", busy, done);
        end
        hold_bad = 0;
        while (!done && cyc < 40) begin
            if (res !== 32'd14) hold_bad++;
            if (cyc == 10) begin op = 2'b01; a = 32'd50; b = 32'd5; start = 1'b1; end
            else start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        $display("b2b second DIVU 9/3 res=%h lat=%0d", res, cyc);
        n_vec++;
        if (hold_bad !== 0) begin n_err++; $display("FAIL b2b_res_hold: %0d cycles with res != 0000000e", hold_bad); end
        n_vec++;
        if (cyc !== 33 || res !== 32'd3) begin
            n_err++; $display("FAIL b2b_second: lat=%0d res=%h, required 33/00000003", cyc, res);
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL b2b_ignored_start: busy=%b done=%b, required 0/0", busy, done);
        end
    endtask

    task automatic test_flush();
        int lat, bc, saw_done, res_bad;
        logic [31:0] r;
        logic da;
        do_op(2'b01, 32'd9, 32'd3, lat, bc, r, da);
        n_vec++;
        if (r !== 32'd3) begin n_err++; $display("FAIL flush_pre: got %h, required 00000003", r); end
        @(negedge clk);
        op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 10; c++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        $display("flush at cycle 10: busy=%b done=%b res=%h", busy, done, res);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || res !== 32'd3) begin
            n_err++; $display("FAIL flush_abort: busy=%b done=%b res=%h, required 0/0/00000003", busy, done, res);
        end
        saw_done = 0;
        res_bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_done++;
            if (res !== 32'd3) res_bad++;
        end
        n_vec++;
        if (saw_done !== 0 || res_bad !== 0) begin
            n_err++; $display("FAIL flush_quiet: %0d active cycles, %0d res changes, required 0/0", saw_done, res_bad);
        end
    endtask

    task automatic test_random();
        int lat, bc, el, kind;
        logic [1:0] o;
        logic [31:0] x, y, r, e;
        logic da;
        for (int i = 0; i < 60; i++) begin
            o    = 2'($urandom_range(0, 3));
            x    = $urandom;
            kind = $urandom_range(0, 9);
            case (kind)
                0: y = 32'h0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: y = $urandom_range(1, 15);
                3: y = x;
                4: begin x = $urandom_range(0, 50); y = $urandom; end
                default: y = $urandom;
            endcase
            do_op(o, x, y, lat, bc, r, da);
            e  = ref_result(o, x, y);
            el = ref_latency(o, x, y);
            $display("random #%0d op=%0d a=%h b=%h res=%h exp=%h lat=%0d", i, o, x, y, r, e, lat);
            n_vec++;
            if (r !== e) begin n_err++; $display("FAIL random_res[%0d]: got %h, required %h", i, r, e); end
            n_vec++;
            if (lat !== el) begin n_err++; $display("FAIL random_lat[%0d]: got %0d, required %0d", i, lat, el); end
        end
    endtask

    task automatic test_async_reset();
        int lat, bc;
        logic [31:0] r;
        logic da;
        do_op(2'b01, 32'd100, 32'd7, lat, bc, r, da);
        n_vec++;
        if (r !== 32'd14) begin n_err++; $display("FAIL arst_pre: got %h, required 0000000e", r); end
        @(negedge clk);
        op = 2'b00; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 20; c++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset mid-CALC: busy=%b done=%b res=%h", busy, done, res);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || res !== 32'h0) begin
            n_err++; $display("FAIL arst_outputs: busy=%b done=%b res=%h, required 0/0/00000000", busy, done, res);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(2'b00, 32'd1000, 32'd3, lat, bc, r, da);
        n_vec++;
        if (r !== 32'd333 || lat !== 33) begin
            n_err++; $display("FAIL arst_recover: res=%h lat=%0d, required 0000014d/33", r, lat);
        end
    endtask

    initial begin
        test_reset();
        test_divide();
        test_fast_path();
        test_back_to_back();
        test_flush();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
